button_bank: RTL and testbench



---
 rtl/buttons_pkg.sv | 20 ++
 rtl/button_channel.sv | 124 ++++++++++++
 rtl/button_bank.sv | 42 ++++
 tb/tb_button_bank.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/buttons_pkg.sv
// rtl/buttons_pkg.sv - shared hold FSM encoding and counter width helpers for the button bank
package buttons_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_HOLD = 2'd1,
    REPEAT    = 2'd2
  } hold_state_t;

  function automatic int hold_cnt_width(input int hold_ticks, input int repeat_ticks);
    int m;
    m = (hold_ticks > repeat_ticks) ? hold_ticks : repeat_ticks;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

  function automatic int dbnc_cnt_width(input int ticks);
    return (ticks <= 1) ? 1 : $clog2(ticks);
  endfunction

endpackage

// File: rtl/button_channel.sv
// rtl/button_channel.sv - one channel: synchroniser, debounce, edge pulses and long-press FSM
module button_channel
  import buttons_pkg::*;
#(
  parameter int SYNC_STAGES      = 2,
  parameter int DEBOUNCING_TICKS = 4,
  parameter int HOLD_TICKS       = 1000,
  parameter int REPEAT_TICKS     = 200
) (
  input  logic clk,
  input  logic rst,
  input  logic norm,
  output logic pressed,
  output logic press_pulse,
  output logic release_pulse,
  output logic hold_pulse
);

  localparam int DCW = dbnc_cnt_width(DEBOUNCING_TICKS);
  localparam int HCW = hold_cnt_width(HOLD_TICKS, REPEAT_TICKS);
  localparam logic [DCW-1:0] DB_LAST = DCW'(DEBOUNCING_TICKS - 1);
  localparam logic [DCW-1:0] DB_ONE  = DCW'(1);
  localparam logic [HCW-1:0] HOLD_V  = HCW'(HOLD_TICKS);
  localparam logic [HCW-1:0] REP_V   = HCW'(REPEAT_TICKS);
  localparam logic [HCW-1:0] HC_ONE  = HCW'(1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced;
  logic                   stable;
  logic [DCW-1:0]         cnt;
  hold_state_t            state;
  logic [HCW-1:0]         hc;
  logic                   accept;
  logic                   press_ev;
  logic                   rel_ev;

  assign synced   = sync_q[SYNC_STAGES-1];
  assign accept   = (synced != stable) && (cnt == DB_LAST);
  assign press_ev = accept & synced;
  assign rel_ev   = accept & ~synced;
  assign pressed  = stable;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], norm};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stable        <= 1'b0;
      cnt           <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      if (synced == stable) begin
        cnt <= '0;
      end else if (accept) begin
        stable        <= synced;
        cnt           <= '0;
        press_pulse   <= synced;
        release_pulse <= ~synced;
      end else begin
        cnt <= cnt + DB_ONE;
      end
    end
  end

  // The FSM reacts to the accept event itself, so hc is already 1 in the press_pulse cycle
  // and a match at hc == N lands the registered hold_pulse exactly N cycles after press_pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      hc         <= '0;
      hold_pulse <= 1'b0;
    end else begin
      hold_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (press_ev) begin
            state <= WAIT_HOLD;
            hc    <= HC_ONE;
          end
        end
        WAIT_HOLD: begin
          if (rel_ev) begin
            state <= IDLE;
            hc    <= '0;
          end else if (hc == HOLD_V) begin
            hold_pulse <= 1'b1;
            if (REPEAT_TICKS == 0) begin
              hc <= '0;
            end else begin
              state <= REPEAT;
              hc    <= HC_ONE;
            end
          end else if (hc != '0) begin
            hc <= hc + HC_ONE;
          end
        end
        REPEAT: begin
          if (rel_ev) begin
            state <= IDLE;
            hc    <= '0;
          end else if (hc == REP_V) begin
            hold_pulse <= 1'b1;
            hc         <= HC_ONE;
          end else begin
            hc <= hc + HC_ONE;
          end
        end
        default: begin
          state <= IDLE;
          hc    <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/button_bank.sv
// rtl/button_bank.sv - N-channel debounced pushbutton block with press/release/hold events
module button_bank
  import buttons_pkg::*;
#(
  parameter int CHANNELS         = 4,
  parameter int ACTIVE_LOW       = 1,
  parameter int SYNC_STAGES      = 2,
  parameter int DEBOUNCING_TICKS = 4,
  parameter int HOLD_TICKS       = 1000,
  parameter int REPEAT_TICKS     = 200
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] button_pins,
  output logic [CHANNELS-1:0] pressed,
  output logic [CHANNELS-1:0] press_pulse,
  output logic [CHANNELS-1:0] release_pulse,
  output logic [CHANNELS-1:0] hold_pulse
);

  logic [CHANNELS-1:0] norm;

  assign norm = (ACTIVE_LOW != 0) ? ~button_pins : button_pins;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    button_channel #(
      .SYNC_STAGES      (SYNC_STAGES),
      .DEBOUNCING_TICKS (DEBOUNCING_TICKS),
      .HOLD_TICKS       (HOLD_TICKS),
      .REPEAT_TICKS     (REPEAT_TICKS)
    ) u_ch (
      .clk           (clk),
      .rst           (rst),
      .norm          (norm[g]),
      .pressed       (pressed[g]),
      .press_pulse   (press_pulse[g]),
      .release_pulse (release_pulse[g]),
      .hold_pulse    (hold_pulse[g])
    );
  end

endmodule

// File: tb/tb_button_bank.sv
// tb/tb_button_bank.sv - scoreboard bench for button_bank (repeat, no-repeat and active-high instances)
module tb_button_bank;

  localparam int K_PRESS = 0;
  localparam int K_REL   = 1;
  localparam int K_HOLD  = 2;

  typedef struct {
    int cyc;
    int inst;
    int kind;
    int ch;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] pins_main = 4'hF;
  logic [3:0] pins_nr   = 4'hF;
  logic [3:0] pins_ah   = 4'h0;
  logic [3:0] pr [3];
  logic [3:0] pp [3];
  logic [3:0] rp [3];
  logic [3:0] hp [3];

  int  cyc = 0;
  int  vectors = 0;
  int  miscompares = 0;
  bit  mon_en = 1'b0;
  ev_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  button_bank #(.CHANNELS(4), .ACTIVE_LOW(1), .SYNC_STAGES(2), .DEBOUNCING_TICKS(4),
                .HOLD_TICKS(10), .REPEAT_TICKS(3)) dut_main (
    .clk(clk), .rst(rst), .button_pins(pins_main), .pressed(pr[0]),
    .press_pulse(pp[0]), .release_pulse(rp[0]), .hold_pulse(hp[0]));

  button_bank #(.CHANNELS(4), .ACTIVE_LOW(1), .SYNC_STAGES(2), .DEBOUNCING_TICKS(4),
                .HOLD_TICKS(10), .REPEAT_TICKS(0)) dut_nr (
    .clk(clk), .rst(rst), .button_pins(pins_nr), .pressed(pr[1]),
    .press_pulse(pp[1]), .release_pulse(rp[1]), .hold_pulse(hp[1]));

  button_bank #(.CHANNELS(4), .ACTIVE_LOW(0), .SYNC_STAGES(2), .DEBOUNCING_TICKS(4),
                .HOLD_TICKS(10), .REPEAT_TICKS(3)) dut_ah (
    .clk(clk), .rst(rst), .button_pins(pins_ah), .pressed(pr[2]),
    .press_pulse(pp[2]), .release_pulse(rp[2]), .hold_pulse(hp[2]));

  // Every cycle, every pulse output of every instance must equal exactly what the scoreboard holds.
  always @(negedge clk) begin : monitor
    logic [3:0] ep, er, eh;
    if (mon_en) begin
      for (int i = 0; i < 3; i++) begin
        ep = '0; er = '0; eh = '0;
        for (int k = sb.size() - 1; k >= 0; k--) begin
          if (sb[k].inst == i && sb[k].cyc == cyc) begin
            case (sb[k].kind)
              K_PRESS: ep[sb[k].ch] = 1'b1;
              K_REL:   er[sb[k].ch] = 1'b1;
              default: eh[sb[k].ch] = 1'b1;
            endcase
            sb.delete(k);
          end
        end
        vectors++;
        if (pp[i] !== ep) begin
          miscompares++;
          $display("FAIL press_pulse inst%0d cyc%0d: got %b want %b", i, cyc, pp[i], ep);
        end
        vectors++;
        if (rp[i] !== er) begin
          miscompares++;
          $display("FAIL release_pulse inst%0d cyc%0d: got %b want %b", i, cyc, rp[i], er);
        end
        vectors++;
        if (hp[i] !== eh) begin
          miscompares++;
          $display("FAIL hold_pulse inst%0d cyc%0d: got %b want %b", i, cyc, hp[i], eh);
        end
      end
    end
  end

  task automatic go_to(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic push_ev(input int c, input int inst, input int kind, input int ch);
    ev_t e;
    e.cyc = c; e.inst = inst; e.kind = kind; e.ch = ch;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    go_to(2);
    mon_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (pr[i] !== 4'h0) begin
        miscompares++;
        $display("FAIL reset_pressed inst%0d: got %b want 0000", i, pr[i]);
      end
    end
    rst = 1'b0;
    go_to(cyc + 4);
  endtask

  task automatic test_clean_press();
    int c;
    c = cyc;
    pins_main[0] = 1'b0;
    push_ev(c + 6, 0, K_PRESS, 0);
    go_to(c + 5);
    vectors++;
    if (pr[0][0] !== 1'b0) begin
      miscompares++; $display("FAIL clean_early: got %b want 0", pr[0][0]);
    end
    go_to(c + 6);
    vectors++;
    if (pr[0][0] !== 1'b1) begin
      miscompares++; $display("FAIL clean_accept: got %b want 1", pr[0][0]);
    end
    go_to(c + 8);
    pins_main[0] = 1'b1;
    push_ev(c + 14, 0, K_REL, 0);
    go_to(c + 13);
    vectors++;
    if (pr[0][0] !== 1'b1) begin
      miscompares++; $display("FAIL clean_rel_early: got %b want 1", pr[0][0]);
    end
    go_to(c + 14);
    vectors++;
    if (pr[0][0] !== 1'b0) begin
      miscompares++; $display("FAIL clean_released: got %b want 0", pr[0][0]);
    end
    go_to(c + 18);
  endtask

  task automatic test_bounce();
    int c;
    logic seq [8];
    seq = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    c = cyc;
    for (int i = 0; i < 8; i++) begin
      go_to(c + i);
      pins_main[1] = seq[i];
    end
    for (int i = 0; i < 10; i++) begin
      go_to(c + 8 + i);
      vectors++;
      if (pr[0][1] !== 1'b0) begin
        miscompares++; $display("FAIL bounce_pressed cyc%0d: got %b want 0", cyc, pr[0][1]);
      end
    end
  endtask

  task automatic test_long_press();
    int c, a;
    c = cyc;
    a = c + 6;
    pins_main[2] = 1'b0;
    push_ev(a, 0, K_PRESS, 2);
    for (int t = 10; t <= 28; t += 3) push_ev(a + t, 0, K_HOLD, 2);
    // release lands on a+31, the cycle a further hold would have fired
    go_to(a + 25);
    pins_main[2] = 1'b1;
    push_ev(a + 31, 0, K_REL, 2);
    go_to(a + 30);
    vectors++;
    if (pr[0][2] !== 1'b1) begin
      miscompares++; $display("FAIL long_held: got %b want 1", pr[0][2]);
    end
    go_to(a + 42);
  endtask

  task automatic test_no_repeat();
    int c;
    c = cyc;
    pins_nr[0] = 1'b0;
    push_ev(c + 6, 1, K_PRESS, 0);
    push_ev(c + 16, 1, K_HOLD, 0);
    go_to(c + 40);
    pins_nr[0] = 1'b1;
    push_ev(c + 46, 1, K_REL, 0);
    go_to(c + 45);
    vectors++;
    if (pr[1][0] !== 1'b1) begin
      miscompares++; $display("FAIL norep_held: got %b want 1", pr[1][0]);
    end
    go_to(c + 50);
  endtask

  task automatic test_simul_reset();
    int c;
    c = cyc;
    pins_main[0] = 1'b0;
    pins_main[3] = 1'b0;
    push_ev(c + 6, 0, K_PRESS, 0);
    push_ev(c + 6, 0, K_PRESS, 3);
    go_to(c + 10);
    vectors++;
    if (pr[0] !== 4'b1001) begin
      miscompares++; $display("FAIL simul_pressed: got %b want 1001", pr[0]);
    end
    rst = 1'b1;
    go_to(c + 11);
    rst = 1'b0;
    vectors++;
    if (pr[0] !== 4'b0000) begin
      miscompares++; $display("FAIL simul_reset: got %b want 0000", pr[0]);
    end
    push_ev(c + 17, 0, K_PRESS, 0);
    push_ev(c + 17, 0, K_PRESS, 3);
    go_to(c + 16);
    vectors++;
    if (pr[0] !== 4'b0000) begin
      miscompares++; $display("FAIL simul_redetect_early: got %b want 0000", pr[0]);
    end
    go_to(c + 18);
    pins_main[0] = 1'b1;
    pins_main[3] = 1'b1;
    push_ev(c + 24, 0, K_REL, 0);
    push_ev(c + 24, 0, K_REL, 3);
    go_to(c + 17 + 10);
    vectors++;
    if (pr[0] !== 4'b0000) begin
      miscompares++; $display("FAIL simul_released: got %b want 0000", pr[0]);
    end
    go_to(c + 32);
  endtask

  task automatic test_active_high();
    int c;
    c = cyc;
    pins_ah[0] = 1'b1;
    push_ev(c + 6, 2, K_PRESS, 0);
    go_to(c + 5);
    vectors++;
    if (pr[2] !== 4'b0000) begin
      miscompares++; $display("FAIL ah_early: got %b want 0000", pr[2]);
    end
    go_to(c + 6);
    vectors++;
    if (pr[2] !== 4'b0001) begin
      miscompares++; $display("FAIL ah_accept: got %b want 0001", pr[2]);
    end
    go_to(c + 8);
    pins_ah[0] = 1'b0;
    push_ev(c + 14, 2, K_REL, 0);
    go_to(c + 18);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_long_press();
    test_no_repeat();
    test_simul_reset();
    test_active_high();
    go_to(cyc + 2);
    vectors++;
    if (sb.size() !== 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
